// File: rtl/mux41_using21.sv
// 2:1 multiplexer leaf, W bits wide: y = s ? b : a.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module mux21 #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = s ? b : a;

endmodule

// 4:1 lane multiplexer built as a two-level tree of mux21, with a registered copy.
// Latency: y is combinational (0 cycles); y_q / y_q_valid appear one cycle after capture.
// Backpressure: none; en gates capture, y_q holds while en is low, rst clears synchronously.
module mux41_using21 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [4*W-1:0] I,
    input  logic [1:0]     sel,
    input  logic           en,
    output logic [W-1:0]   y,
    output logic [W-1:0]   y_q,
    output logic           y_q_valid
);

    logic [W-1:0] lane0;
    logic [W-1:0] lane1;
    logic [W-1:0] lane2;
    logic [W-1:0] lane3;
    logic [W-1:0] mux_a_y;
    logic [W-1:0] mux_b_y;

    assign lane0 = I[0*W +: W];
    assign lane1 = I[1*W +: W];
    assign lane2 = I[2*W +: W];
    assign lane3 = I[3*W +: W];

    // First level: sel[0] picks within each lane pair.
    mux21 #(.W(W)) u_mux_a (
        .a (lane0),
        .b (lane1),
        .s (sel[0]),
        .y (mux_a_y)
    );

    mux21 #(.W(W)) u_mux_b (
        .a (lane2),
        .b (lane3),
        .s (sel[0]),
        .y (mux_b_y)
    );

    // Second level: sel[1] picks between the pair winners; reset never touches y.
    mux21 #(.W(W)) u_mux_c (
        .a (mux_a_y),
        .b (mux_b_y),
        .s (sel[1]),
        .y (y)
    );

    // Capture y on enabled edges; reset takes priority over a simultaneous capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_q_valid <= 1'b0;
        end else if (en) begin
            y_q       <= y;
            y_q_valid <= 1'b1;
        end else begin
            y_q_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux41_using21.sv
module tb_mux41_using21;

    localparam int W = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [3:0]   I   = 4'b0000;
    logic [1:0]   sel = 2'b00;
    logic [W-1:0] y;
    logic [W-1:0] y_q;
    logic         y_q_valid;

    mux41_using21 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .I         (I),
        .sel       (sel),
        .en        (en),
        .y         (y),
        .y_q       (y_q),
        .y_q_valid (y_q_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] i;
        logic [1:0] s;
        logic       exp_y;
    } vec_t;

    typedef struct {
        logic q;
        logic v;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic model_q = 1'b0;
    logic model_v = 1'b0;

    function automatic logic lane_of(input logic [3:0] i, input logic [1:0] s);
        logic [3:0] t;
        t = i >> s;
        return t[0];
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model update for one edge; result queued for the post-edge compare.
    task automatic push_expect(input logic r, input logic e, input logic cur_y);
        exp_t x;
        if (r) begin
            model_q = 1'b0;
            model_v = 1'b0;
        end else if (e) begin
            model_q = cur_y;
            model_v = 1'b1;
        end else begin
            model_v = 1'b0;
        end
        x.q = model_q;
        x.v = model_v;
        sbq.push_back(x);
    endtask

    task automatic pop_compare(input string name);
        exp_t x;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: scoreboard empty, got y_q=%b valid=%b", name, y_q, y_q_valid);
        end else begin
            x = sbq.pop_front();
            check1({name, "_yq"}, y_q, x.q);
            check1({name, "_vld"}, y_q_valid, x.v);
        end
    endtask

    // One clock: drive at negedge, check y, queue expected registered state, check after edge.
    task automatic step(input logic r, input logic e, input logic [3:0] i,
                        input logic [1:0] s, input string name);
        logic ey;
        @(negedge clk);
        rst = r;
        en  = e;
        I   = i;
        sel = s;
        ey  = lane_of(i, s);
        #1;
        check1({name, "_y"}, y, ey);
        push_expect(r, e, ey);
        @(posedge clk);
        #1;
        pop_compare(name);
        check1({name, "_ypost"}, y, ey);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{i: 4'b0010, s: 2'b10, exp_y: 1'b0};
        vt[1] = '{i: 4'b0111, s: 2'b10, exp_y: 1'b1};
        vt[2] = '{i: 4'b1010, s: 2'b00, exp_y: 1'b0};
        vt[3] = '{i: 4'b0011, s: 2'b01, exp_y: 1'b1};
        vt[4] = '{i: 4'b1000, s: 2'b11, exp_y: 1'b1};
        vt[5] = '{i: 4'b0111, s: 2'b11, exp_y: 1'b0};

        // Reset state, y still follows inputs during reset.
        step(1'b1, 1'b0, 4'b0100, 2'b10, "reset0");
        step(1'b1, 1'b1, 4'b0001, 2'b00, "reset1");

        // Directed table: y checked before the edge against the table value.
        foreach (vt[k]) begin
            @(negedge clk);
            rst = 1'b0;
            en  = 1'b0;
            I   = vt[k].i;
            sel = vt[k].s;
            #1;
            check1($sformatf("vec%0d_y", k), y, vt[k].exp_y);
            push_expect(1'b0, 1'b0, vt[k].exp_y);
            @(posedge clk);
            #1;
            pop_compare($sformatf("vec%0d", k));
        end

        // Exhaustive combinational sweep, no clock involvement.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 4; b++) begin
                logic [3:0] iv;
                logic [1:0] sv;
                iv = a[3:0];
                sv = b[1:0];
                I   = iv;
                sel = sv;
                #1;
                check1($sformatf("exh_i%0h_s%0d", iv, sv), y, iv[sv]);
            end
        end

        // Registered path after a fresh reset.
        step(1'b1, 1'b0, 4'b0000, 2'b00, "rp_rst");
        step(1'b0, 1'b1, 4'b1000, 2'b11, "rp_cap");
        check1("rp_cap_yq_abs", y_q, 1'b1);
        check1("rp_cap_vld_abs", y_q_valid, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 2'b11, "rp_hold");
        check1("rp_hold_yq_abs", y_q, 1'b1);
        check1("rp_hold_vld_abs", y_q_valid, 1'b0);
        check1("rp_hold_y_abs", y, 1'b0);

        // Reset beats a simultaneous capture; y stays 1 throughout.
        step(1'b0, 1'b1, 4'b1111, 2'b01, "rpri_pre");
        step(1'b1, 1'b1, 4'b1111, 2'b01, "rpri");
        check1("rpri_yq_abs", y_q, 1'b0);
        check1("rpri_vld_abs", y_q_valid, 1'b0);
        check1("rpri_y_abs", y, 1'b1);
        // Capture resumes on the first edge after reset falls.
        step(1'b0, 1'b1, 4'b1111, 2'b01, "rpost");

        // Mid-cycle input change: only the value present at the edge is captured.
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        I   = 4'b0001;
        sel = 2'b00;
        #1;
        check1("mid_y_first", y, 1'b1);
        #2;
        I = 4'b1110;
        #1;
        check1("mid_y_second", y, 1'b0);
        push_expect(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        pop_compare("mid");
        // Inputs wander with en low: y_q must not move.
        en = 1'b0;
        I  = 4'b1111;
        #1;
        check1("mid_wander_y", y, 1'b1);
        check1("mid_wander_yq", y_q, 1'b0);
        push_expect(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        pop_compare("mid_hold");

        // Back-to-back captures with random data; valid must stay high.
        for (int n = 0; n < 24; n++) begin
            step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 $sformatf("b2b%0d", n));
        end
        // Random mix of enable and reset.
        for (int n = 0; n < 24; n++) begin
            step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 $sformatf("mix%0d", n));
        end

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule
